// File: rtl/cu_edge_line_unpacker_if.sv
// rtl/cu_edge_line_unpacker_if.sv - cacheline-half input and edge-word stream bundle
// The master drives cacheline halves and consumes edge words; the unpacker is the slave.
interface cu_edge_line_unpacker_if #(
    parameter int WORD_W     = 32,
    parameter int HALF_WORDS = 16
);
    localparam int LINE_WORDS = 2 * HALF_WORDS;
    localparam int IDX_W      = $clog2(LINE_WORDS);

    logic                         data_0_valid;
    logic [HALF_WORDS*WORD_W-1:0] data_0;
    logic [IDX_W-1:0]             line_start;
    logic [IDX_W:0]               line_words;
    logic                         data_1_valid;
    logic [HALF_WORDS*WORD_W-1:0] data_1;
    logic                         in_ready;

    logic                         edge_valid;
    logic [WORD_W-1:0]            edge_data;
    logic                         edge_last;
    logic                         edge_ready;

    modport master (
        output data_0_valid, data_0, line_start, line_words,
        output data_1_valid, data_1, edge_ready,
        input  in_ready, edge_valid, edge_data, edge_last
    );

    modport slave (
        input  data_0_valid, data_0, line_start, line_words,
        input  data_1_valid, data_1, edge_ready,
        output in_ready, edge_valid, edge_data, edge_last
    );
endinterface

// File: rtl/cu_edge_line_unpacker.sv
// rtl/cu_edge_line_unpacker.sv - captures a two-half cacheline and streams a window of its words
// Words line_start .. line_start+count-1 are emitted in order, count clamped to the line end.
module cu_edge_line_unpacker #(
    parameter int WORD_W     = 32,
    parameter int HALF_WORDS = 16
) (
    input  logic                      clock,
    input  logic                      rstn_in,
    input  logic                      enabled_in,
    cu_edge_line_unpacker_if.slave    bus,
    output logic [31:0]               edges_emitted,
    output logic                      order_error,
    output logic                      overflow_error
);
    localparam int LINE_WORDS = 2 * HALF_WORDS;
    localparam int IDX_W      = $clog2(LINE_WORDS);

    localparam logic [IDX_W:0]   LINE_COUNT = (IDX_W+1)'(LINE_WORDS);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_HALF1 = 2'd1;
    localparam logic [1:0] ST_DRAIN      = 2'd2;

    logic [1:0]        state;
    logic              live;
    logic [WORD_W-1:0] line_buf [LINE_WORDS];
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  last_idx;

    logic [IDX_W:0]    start_ext;
    logic [IDX_W:0]    room;
    logic [IDX_W:0]    eff_count;
    logic [IDX_W-1:0]  cap_last;
    logic              active;

    // Clamp is done one bit wider than the index so a full-line count never wraps.
    always_comb begin
        start_ext = {1'b0, bus.line_start};
        room      = LINE_COUNT - start_ext;
        eff_count = (bus.line_words < room) ? bus.line_words : room;
        cap_last  = bus.line_start + eff_count[IDX_W-1:0] - IDX_ONE;
    end

    // live keeps in_ready low until the first edge after reset release.
    assign active         = enabled_in && live;
    assign bus.in_ready   = active && (state == ST_IDLE);
    assign bus.edge_valid = active && (state == ST_DRAIN);
    assign bus.edge_data  = line_buf[idx];
    assign bus.edge_last  = (state == ST_DRAIN) && (idx == last_idx);

    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            state          <= ST_IDLE;
            live           <= 1'b0;
            idx            <= '0;
            last_idx       <= '0;
            edges_emitted  <= '0;
            order_error    <= 1'b0;
            overflow_error <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_buf[i] <= '0;
            end
        end else begin
            live <= 1'b1;
            if (active) begin
                case (state)
                    ST_IDLE: begin
                        if (bus.data_0_valid) begin
                            for (int i = 0; i < HALF_WORDS; i++) begin
                                line_buf[i] <= bus.data_0[i*WORD_W +: WORD_W];
                            end
                            if (bus.data_1_valid) begin
                                for (int i = 0; i < HALF_WORDS; i++) begin
                                    line_buf[HALF_WORDS+i] <= bus.data_1[i*WORD_W +: WORD_W];
                                end
                            end
                            idx      <= bus.line_start;
                            last_idx <= cap_last;
                            // An empty window needs no second half, so the line ends here.
                            if (eff_count == '0) begin
                                state <= ST_IDLE;
                            end else if (bus.data_1_valid) begin
                                state <= ST_DRAIN;
                            end else begin
                                state <= ST_WAIT_HALF1;
                            end
                        end else if (bus.data_1_valid) begin
                            order_error <= 1'b1;
                        end
                    end
                    ST_WAIT_HALF1: begin
                        if (bus.data_0_valid) begin
                            order_error <= 1'b1;
                        end else if (bus.data_1_valid) begin
                            for (int i = 0; i < HALF_WORDS; i++) begin
                                line_buf[HALF_WORDS+i] <= bus.data_1[i*WORD_W +: WORD_W];
                            end
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (bus.data_0_valid || bus.data_1_valid) begin
                            overflow_error <= 1'b1;
                        end
                        if (bus.edge_ready) begin
                            edges_emitted <= edges_emitted + 32'd1;
                            if (idx == last_idx) begin
                                state <= ST_IDLE;
                            end else begin
                                idx <= idx + IDX_ONE;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cu_edge_line_unpacker.sv
// tb/tb_cu_edge_line_unpacker.sv - scoreboard bench for cu_edge_line_unpacker
module tb_cu_edge_line_unpacker;
    localparam int WORD_W     = 32;
    localparam int HALF_WORDS = 16;
    localparam int LINE_WORDS = 2 * HALF_WORDS;

    logic        clock;
    logic        rstn_in;
    logic        enabled_in;
    logic [31:0] edges_emitted;
    logic        order_error;
    logic        overflow_error;

    cu_edge_line_unpacker_if #(.WORD_W(WORD_W), .HALF_WORDS(HALF_WORDS)) bus ();

    cu_edge_line_unpacker #(.WORD_W(WORD_W), .HALF_WORDS(HALF_WORDS)) dut (
        .clock          (clock),
        .rstn_in        (rstn_in),
        .enabled_in     (enabled_in),
        .bus            (bus),
        .edges_emitted  (edges_emitted),
        .order_error    (order_error),
        .overflow_error (overflow_error)
    );

    typedef struct packed {
        logic [WORD_W-1:0] d;
        logic              last;
    } exp_t;

    exp_t              sb [$];
    int                errors = 0;
    int                checks = 0;
    int                exp_total = 0;
    int                pops = 0;
    int                ready_mode = 0;
    bit                hold_pending = 0;
    logic [WORD_W-1:0] hold_data;
    logic              hold_last;
    bit                exp_order = 0;
    bit                exp_overflow = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        #1;
        bus.edge_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every handshake and checks stalls hold the word.
    always @(negedge clock) begin
        if (rstn_in && enabled_in) begin
            if (hold_pending) begin
                check("hold_valid", bus.edge_valid, 1);
                check("hold_data", bus.edge_data, hold_data);
                check("hold_last", bus.edge_last, hold_last);
                hold_pending = 0;
            end
            if (bus.edge_valid) begin
                if (bus.edge_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h expected no word", bus.edge_data);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("edge_data", bus.edge_data, e.d);
                        check("edge_last", bus.edge_last, e.last);
                        pops++;
                    end
                end else begin
                    hold_pending = 1;
                    hold_data    = bus.edge_data;
                    hold_last    = bus.edge_last;
                end
            end
        end else if (rstn_in) begin
            check("valid_when_disabled", bus.edge_valid, 0);
        end
    end

    task automatic send_line(input int s, input int n, input int gap, input bit seq_words);
        logic [WORD_W-1:0] w [LINE_WORDS];
        int   eff;
        int   t;
        exp_t e;
        for (int i = 0; i < LINE_WORDS; i++) begin
            w[i] = seq_words ? 32'(i + 1) : $urandom;
        end
        eff = (n < LINE_WORDS - s) ? n : LINE_WORDS - s;
        t = 0;
        while (!bus.in_ready) begin
            @(posedge clock); #1;
            t++;
            if (t > 3000) begin
                check("in_ready_timeout", bus.in_ready, 1);
                return;
            end
        end
        for (int i = 0; i < HALF_WORDS; i++) begin
            bus.data_0[i*WORD_W +: WORD_W] = w[i];
            bus.data_1[i*WORD_W +: WORD_W] = w[HALF_WORDS + i];
        end
        bus.line_start   = 5'(s);
        bus.line_words   = 6'(n);
        bus.data_0_valid = 1'b1;
        bus.data_1_valid = (gap == 0);
        for (int k = 0; k < eff; k++) begin
            e.d    = w[s + k];
            e.last = (k == eff - 1);
            sb.push_back(e);
        end
        exp_total += eff;
        @(posedge clock); #1;
        bus.data_0_valid = 1'b0;
        bus.data_1_valid = 1'b0;
        if (gap > 0 && eff > 0) begin
            repeat (gap - 1) begin
                @(posedge clock); #1;
            end
            bus.data_1_valid = 1'b1;
            @(posedge clock); #1;
            bus.data_1_valid = 1'b0;
        end
        check("first_word_latency", bus.edge_valid, (eff > 0));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (!(sb.size() == 0 && bus.in_ready)) begin
            @(posedge clock); #1;
            t++;
            if (t > 5000) begin
                check("drain_timeout", sb.size(), 0);
                return;
            end
        end
        check("edges_emitted", edges_emitted, 32'(exp_total));
        check("order_error", order_error, exp_order);
        check("overflow_error", overflow_error, exp_overflow);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_edge_valid"}, bus.edge_valid, 0);
        check({tag, "_edge_last"}, bus.edge_last, 0);
        check({tag, "_edge_data"}, bus.edge_data, 0);
        check({tag, "_edges_emitted"}, edges_emitted, 0);
        check({tag, "_order_error"}, order_error, 0);
        check({tag, "_overflow_error"}, overflow_error, 0);
    endtask

    initial begin
        int t;
        rstn_in          = 1'b0;
        enabled_in       = 1'b1;
        bus.edge_ready   = 1'b1;
        bus.data_0_valid = 1'b0;
        bus.data_1_valid = 1'b0;
        bus.data_0       = '0;
        bus.data_1       = '0;
        bus.line_start   = '0;
        bus.line_words   = '0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        rstn_in = 1'b1;
        @(posedge clock); #1;
        check("ready_after_reset", bus.in_ready, 1);

        // Full line, both halves together.
        send_line(0, 32, 0, 1);
        wait_drain();

        // Second half three cycles late, count clamped to the line end.
        send_line(30, 5, 3, 1);
        wait_drain();

        // Randomised lines with random backpressure.
        for (int l = 0; l < 24; l++) begin
            ready_mode = int'($urandom_range(0, 1));
            send_line(int'($urandom_range(0, 31)), int'($urandom_range(0, 32)),
                      int'($urandom_range(0, 3)), 1'b0);
        end
        wait_drain();
        ready_mode = 1;
        send_line(0, 32, 1, 0);
        wait_drain();
        ready_mode = 0;

        // Half 1 alone is an ordering error; then an empty window.
        bus.data_1_valid = 1'b1;
        @(posedge clock); #1;
        bus.data_1_valid = 1'b0;
        exp_order = 1;
        check("order_error_set", order_error, 1);
        check("no_word_after_order_error", bus.edge_valid, 0);
        send_line(9, 0, 1, 0);
        check("idle_after_empty", bus.in_ready, 1);
        wait_drain();

        // Input during drain sets overflow; the line still completes.
        send_line(0, 16, 0, 0);
        repeat (2) begin
            @(posedge clock); #1;
        end
        bus.data_0_valid = 1'b1;
        @(posedge clock); #1;
        bus.data_0_valid = 1'b0;
        exp_overflow = 1;
        check("overflow_error_set", overflow_error, 1);
        wait_drain();

        // Enable dropped mid-drain freezes and then resumes with the same word.
        ready_mode = 1;
        send_line(3, 20, 1, 0);
        repeat (3) begin
            @(posedge clock); #1;
        end
        enabled_in = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
        end
        check("in_ready_disabled", bus.in_ready, 0);
        enabled_in = 1'b1;
        wait_drain();
        ready_mode = 0;

        // Reset mid-line after five words.
        send_line(0, 16, 0, 0);
        pops = 0;
        t = 0;
        while (pops < 5 && t < 1000) begin
            @(negedge clock);
            t++;
        end
        check("five_words_seen", pops, 5);
        #1;
        rstn_in = 1'b0;
        #1;
        sb.delete();
        hold_pending = 0;
        exp_total    = 0;
        exp_order    = 0;
        exp_overflow = 0;
        check_all_zero("midline_reset");
        repeat (2) @(posedge clock);
        #1;
        rstn_in = 1'b1;
        @(posedge clock); #1;
        check("ready_after_midline_reset", bus.in_ready, 1);
        send_line(7, 10, 2, 0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
